alu_vec_result_serializer: RTL and testbench

ALU_VEC_RESULT_SERIALIZER -- requirements
Module: alu_vec_result_serializer

---
 rtl/alu_vec_result_serializer.sv | 106 ++++++++++
 tb/tb_alu_vec_result_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_result_serializer.sv
// Captures one vector of ALU lane results and flags, then streams the enabled
// lanes out lowest-index first over a valid/ready handshake.
module alu_vec_result_serializer #(
    parameter int WIDTH = 8,
    parameter int N_ALU = 4
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       load,
    input  logic [N_ALU-1:0]           lane_en,
    input  logic [2*WIDTH*N_ALU-1:0]   data_in,
    input  logic [N_ALU-1:0]           carry_in,
    input  logic [N_ALU-1:0]           gt_in,
    input  logic [N_ALU-1:0]           eq_in,
    input  logic [N_ALU-1:0]           lt_in,
    input  logic [N_ALU-1:0]           inf_in,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         out_data,
    output logic [$clog2(N_ALU)-1:0]   out_lane,
    output logic [4:0]                 out_flags,
    output logic                       out_last,
    output logic                       done,
    output logic [7:0]                 inf_cnt
);

    localparam int LW = $clog2(N_ALU);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state, state_nxt;
    logic [2*WIDTH*N_ALU-1:0]   data_q;
    logic [N_ALU-1:0]           carry_q, gt_q, eq_q, lt_q, inf_q;
    logic [N_ALU-1:0]           pend_q;
    logic                       done_q;
    logic [7:0]                 inf_cnt_q;
    logic [LW-1:0]              cur;
    logic                       last;
    logic                       xfer;

    // pend_q holds the lanes still to be sent; the current lane is its lowest set bit
    always_comb begin
        cur = '0;
        for (int unsigned i = N_ALU; i > 0; i--) begin
            if (pend_q[i-1]) cur = LW'(i - 1);
        end
    end

    assign last = (pend_q & (pend_q - {{(N_ALU-1){1'b0}}, 1'b1})) == '0;
    assign xfer = (state == SEND) && out_ready;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load && (lane_en != '0)) state_nxt = SEND;
            SEND: if (out_ready && last)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            data_q    <= '0;
            carry_q   <= '0;
            gt_q      <= '0;
            eq_q      <= '0;
            lt_q      <= '0;
            inf_q     <= '0;
            pend_q    <= '0;
            done_q    <= 1'b0;
            inf_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if ((state == IDLE) && load) begin
                data_q  <= data_in;
                carry_q <= carry_in;
                gt_q    <= gt_in;
                eq_q    <= eq_in;
                lt_q    <= lt_in;
                inf_q   <= inf_in;
                pend_q  <= lane_en;
                done_q  <= (lane_en == '0);
            end else if (xfer) begin
                pend_q <= pend_q & (pend_q - {{(N_ALU-1){1'b0}}, 1'b1});
                done_q <= last;
                if (inf_q[cur] && (inf_cnt_q != '1)) inf_cnt_q <= inf_cnt_q + 8'd1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? data_q[int'(cur)*2*WIDTH +: 2*WIDTH] : '0;
    assign out_lane  = out_valid ? cur : '0;
    assign out_flags = out_valid ? {inf_q[cur], lt_q[cur], eq_q[cur], gt_q[cur], carry_q[cur]} : '0;
    assign out_last  = out_valid & last;
    assign done      = done_q;
    assign inf_cnt   = inf_cnt_q;

endmodule

// File: tb/tb_alu_vec_result_serializer.sv
// Randomized and directed checks of alu_vec_result_serializer against a
// queue-based model of the lanes still owed to the consumer.
module tb_alu_vec_result_serializer;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int DW = 2 * W;

    logic            clk, arst, load, out_ready;
    logic [N-1:0]    lane_en, carry_in, gt_in, eq_in, lt_in, inf_in;
    logic [DW*N-1:0] data_in;
    logic            in_ready, out_valid, out_last, done;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_lane;
    logic [4:0]      out_flags;
    logic [7:0]      inf_cnt;

    alu_vec_result_serializer #(.WIDTH(W), .N_ALU(N)) dut (
        .clk(clk), .arst(arst), .load(load), .lane_en(lane_en), .data_in(data_in),
        .carry_in(carry_in), .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in), .inf_in(inf_in),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lane(out_lane), .out_flags(out_flags),
        .out_last(out_last), .done(done), .inf_cnt(inf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            lane;
        logic [4:0]    flags;
    } lane_t;

    lane_t exp_q[$];
    logic  exp_done;
    int    exp_inf;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_done = 1'b0;
        exp_inf  = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        lane_t e;
        logic  nd;
        nd = 1'b0;
        if (!arst) begin
            model_reset();
            return;
        end
        if (exp_q.size() != 0) begin
            if (out_ready) begin
                e = exp_q.pop_front();
                if (e.flags[4] && exp_inf < 255) exp_inf++;
                if (exp_q.size() == 0) nd = 1'b1;
            end
        end else if (load) begin
            for (int i = 0; i < N; i++) begin
                if (lane_en[i]) begin
                    e.data  = data_in[i*DW +: DW];
                    e.lane  = i;
                    e.flags = {inf_in[i], lt_in[i], eq_in[i], gt_in[i], carry_in[i]};
                    exp_q.push_back(e);
                end
            end
            if (lane_en == '0) nd = 1'b1;
        end
        exp_done = nd;
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, exp_q.size() == 0);
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_lane", out_lane, exp_q[0].lane);
            chk("out_flags", out_flags, exp_q[0].flags);
            chk("out_last", out_last, exp_q.size() == 1);
        end else begin
            chk("idle_data", out_data, 0);
            chk("idle_lane", out_lane, 0);
            chk("idle_flags", out_flags, 0);
            chk("idle_last", out_last, 0);
        end
        chk("done", done, exp_done);
        chk("inf_cnt", inf_cnt, exp_inf);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rand_inputs();
        data_in  = {$urandom, $urandom};
        lane_en  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
        carry_in = N'($urandom);
        gt_in    = N'($urandom);
        eq_in    = N'($urandom);
        lt_in    = N'($urandom);
        inf_in   = N'($urandom);
    endtask

    initial begin
        arst = 1'b0; load = 1'b0; out_ready = 1'b0; lane_en = '0; data_in = '0;
        carry_in = '0; gt_in = '0; eq_in = '0; lt_in = '0; inf_in = '0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_in_ready", in_ready, 1);
        step();
        step();
        arst = 1'b1;
        step();

        // Full vector, ready always high
        rand_inputs();
        lane_en = 4'b1111; data_in = 64'h0004_0003_0002_0001; out_ready = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("full_data", out_data, k + 1);
            chk("full_lane", out_lane, k);
            chk("full_last", out_last, k == 3);
            step();
        end
        chk("full_done", done, 1);

        // Sparse mask: lanes 1 and 3 only, loaded during the done cycle
        rand_inputs();
        lane_en = 4'b1010; load = 1'b1;
        step();
        load = 1'b0;
        chk("sparse_lane1", out_lane, 1);
        chk("sparse_last1", out_last, 0);
        step();
        chk("sparse_lane3", out_lane, 3);
        chk("sparse_last3", out_last, 1);
        step();
        chk("sparse_done", done, 1);

        // Empty mask
        rand_inputs();
        lane_en = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        chk("empty_valid", out_valid, 0);
        chk("empty_done", done, 1);
        chk("empty_ready", in_ready, 1);
        step();
        chk("empty_done_drop", done, 0);

        // Backpressure with loads ignored
        rand_inputs();
        lane_en = 4'b1111; data_in = 64'h4444_3333_2222_1111; load = 1'b1;
        step();
        rand_inputs();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_data", out_data, 16'h1111);
            chk("stall_lane", out_lane, 0);
            chk("stall_ready", in_ready, 0);
        end
        load = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rand_inputs();
            load      = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        load = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // 70 back-to-back all-inf vectors saturate the counter
        rand_inputs();
        lane_en = 4'b1111; inf_in = 4'b1111; load = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 70 * 5; k++) step();
        load = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("inf_sat", inf_cnt, 255);

        // Asynchronous reset in the middle of a vector
        rand_inputs();
        lane_en = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("pre_rst_valid", out_valid, 1);
        #3;
        arst = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_done", done, 0);
        chk("arst_inf", inf_cnt, 0);
        step();
        arst = 1'b1;
        step();
        chk("post_rst_done", done, 0);
        rand_inputs();
        lane_en = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        chk("post_rst_lane", out_lane, 2);
        chk("post_rst_last", out_last, 1);
        step();
        chk("post_rst_fin", done, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
